// File: rtl/channel_pkt_pkg.sv
// Shared definitions for the channel packet format (deframer and future framer).
package channel_pkt_pkg;

    // Framing markers and default payload length of one channel packet.
    localparam logic [15:0] PKT_HEADER_WORD   = 16'hDEAD;
    localparam logic [15:0] PKT_ENDER_WORD    = 16'hBEEF;
    localparam int unsigned PKT_PAYLOAD_WORDS = 125;

    // Parser state: hunting for a header, expecting the timestamp,
    // streaming payload, expecting the ender.
    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_TS   = 2'd1,
        ST_PLD  = 2'd2,
        ST_END  = 2'd3
    } pkt_state_e;

    // Cause reported alongside a framing error pulse.
    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_ENDER_MISMATCH = 2'd1,
        ERR_STALL_TIMEOUT  = 2'd2
    } err_code_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stop at all-ones, clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/channel_packet_deframer.sv
// Receive-side parser for the channel packet stream: checks framing,
// captures the timestamp and forwards payload words with sop/eop marks.
//
// Stream handshake: a din word is consumed on every clock edge where
// din_valid is high (there is no back-pressure); every output valid/pulse
// is registered and asserts exactly one cycle after the consumed word
// that caused it.
module channel_packet_deframer
    import channel_pkt_pkg::*;
#(
    parameter int unsigned       DATA_W        = 16,
    parameter int unsigned       PAYLOAD_WORDS = PKT_PAYLOAD_WORDS,
    parameter logic [DATA_W-1:0] HEADER_WORD   = PKT_HEADER_WORD,
    parameter logic [DATA_W-1:0] ENDER_WORD    = PKT_ENDER_WORD,
    parameter int unsigned       STALL_LIMIT   = 64,
    parameter int unsigned       CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] pld_data,
    output logic              pld_valid,
    output logic              pld_sop,
    output logic              pld_eop,
    output logic [DATA_W-1:0] ts_data,
    output logic              ts_valid,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output pkt_state_e        dbg_state
);

    localparam int unsigned IDX_W   = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(PAYLOAD_WORDS - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    pkt_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout;

    logic [DATA_W-1:0]  pld_data_d, ts_data_d;
    logic               pld_valid_d, pld_sop_d, pld_eop_d, ts_valid_d;
    logic               pkt_ok_d, pkt_err_d;
    logic [1:0]         err_code_d;

    assign dbg_state = state_q;

    // State, payload index and stall timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            idx_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic; a stalled packet is abandoned on its STALL_LIMIT-th idle cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        timeout = 1'b0;
        if (din_valid) begin
            stall_d = '0;
            case (state_q)
                ST_HUNT: if (din == HEADER_WORD) state_d = ST_TS;
                ST_TS: begin
                    idx_d   = '0;
                    state_d = ST_PLD;
                end
                ST_PLD: begin
                    if (idx_q == LAST_IDX) state_d = ST_END;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
                ST_END: begin
                    // A header in the ender slot starts the next packet right away.
                    if (din != ENDER_WORD && din == HEADER_WORD) state_d = ST_TS;
                    else                                          state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (state_q != ST_HUNT) begin
            if (stall_q == STALL_LAST) begin
                timeout = 1'b1;
                stall_d = '0;
                state_d = ST_HUNT;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        pld_data_d  = pld_data;
        pld_valid_d = 1'b0;
        pld_sop_d   = 1'b0;
        pld_eop_d   = 1'b0;
        ts_data_d   = ts_data;
        ts_valid_d  = 1'b0;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code;
        if (din_valid) begin
            case (state_q)
                ST_TS: begin
                    ts_data_d  = din;
                    ts_valid_d = 1'b1;
                end
                ST_PLD: begin
                    pld_data_d  = din;
                    pld_valid_d = 1'b1;
                    pld_sop_d   = (idx_q == '0);
                    pld_eop_d   = (idx_q == LAST_IDX);
                end
                ST_END: begin
                    if (din == ENDER_WORD) begin
                        pkt_ok_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_ENDER_MISMATCH;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_STALL_TIMEOUT;
        end
    end

    // Output registers; reset clears everything, discarding any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pld_data  <= '0;
            pld_valid <= 1'b0;
            pld_sop   <= 1'b0;
            pld_eop   <= 1'b0;
            ts_data   <= '0;
            ts_valid  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            pld_data  <= pld_data_d;
            pld_valid <= pld_valid_d;
            pld_sop   <= pld_sop_d;
            pld_eop   <= pld_eop_d;
            ts_data   <= ts_data_d;
            ts_valid  <= ts_valid_d;
            pkt_ok    <= pkt_ok_d;
            pkt_err   <= pkt_err_d;
            err_code  <= err_code_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pkt_ok_d),
        .count (pkt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pkt_err_d),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_channel_packet_deframer.sv
// Bench for channel_packet_deframer: directed packet scenarios with a
// scoreboard of expected payload words, timestamps and packet events.
module tb_channel_packet_deframer;
    import channel_pkt_pkg::*;

    localparam int DW   = 16;
    localparam int PW   = 125;
    localparam int SL   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] pld_data, ts_data;
    logic          pld_valid, pld_sop, pld_eop, ts_valid, pkt_ok, pkt_err;
    logic [1:0]    err_code;
    logic [CW-1:0] pkt_cnt, err_cnt;
    pkt_state_e    dbg_state;

    channel_packet_deframer #(
        .DATA_W(DW), .PAYLOAD_WORDS(PW), .HEADER_WORD(16'hDEAD),
        .ENDER_WORD(16'hBEEF), .STALL_LIMIT(SL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_sop(pld_sop), .pld_eop(pld_eop),
        .ts_data(ts_data), .ts_valid(ts_valid), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pkt  = 0;
    int exp_err  = 0;

    logic [DW+1:0] exp_q[$];   // {data, sop, eop}
    logic [DW-1:0] ts_q[$];
    logic [3:0]    evt_q[$];   // {ok, err, code}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Scoreboard: compare every output pulse against the expectation queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (pld_valid) begin
                if (exp_q.size() == 0) check("pld_extra", 32'(pld_valid), 32'd0);
                else check("pld_word", {pld_data, pld_sop, pld_eop}, exp_q.pop_front());
            end else if (pld_sop || pld_eop) begin
                check("pld_flags", {pld_sop, pld_eop}, 32'd0);
            end
            if (ts_valid) begin
                if (ts_q.size() == 0) check("ts_extra", 32'(ts_valid), 32'd0);
                else check("ts_data", ts_data, ts_q.pop_front());
            end
            if (pkt_ok || pkt_err) begin
                if (evt_q.size() == 0) begin
                    check("evt_extra", {pkt_ok, pkt_err}, 32'd0);
                end else begin
                    logic [3:0] e;
                    e = evt_q.pop_front();
                    check("evt_kind", {pkt_ok, pkt_err}, e[3:2]);
                    if (e[2]) check("err_code", err_code, e[1:0]);
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] w);
        din = w;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pld"}, {pld_data, pld_valid, pld_sop, pld_eop}, 32'd0);
        check({tag, "_ts"}, {ts_data, ts_valid}, 32'd0);
        check({tag, "_pkt"}, {pkt_ok, pkt_err, err_code, pkt_cnt, err_cnt}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_HUNT));
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        ts_q.delete();
        evt_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        check_zero(tag);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One packet; the payload stalls for stall_len cycles before word stall_at.
    task automatic send_packet(input logic [DW-1:0] ts, input logic [DW-1:0] base,
                               input logic [DW-1:0] ender, input bit with_hdr,
                               input int stall_at, input int stall_len);
        if (with_hdr) send_word(16'hDEAD);
        ts_q.push_back(ts);
        send_word(ts);
        for (int j = 0; j < PW; j++) begin
            if (j == stall_at) idle(stall_len);
            exp_q.push_back({base + DW'(j), (j == 0), (j == PW - 1)});
            send_word(base + DW'(j));
        end
        if (ender == 16'hBEEF) begin
            evt_q.push_back(4'b1000);
            exp_pkt = sat_inc(exp_pkt);
        end else begin
            evt_q.push_back(4'b0101);
            exp_err = sat_inc(exp_err);
        end
        send_word(ender);
    endtask

    // A packet abandoned after n payload words by a full-length stall.
    task automatic send_stalled(input logic [DW-1:0] ts, input logic [DW-1:0] base, input int n);
        send_word(16'hDEAD);
        ts_q.push_back(ts);
        send_word(ts);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back({base + DW'(j), (j == 0), 1'b0});
            send_word(base + DW'(j));
        end
        evt_q.push_back(4'b0110);
        exp_err = sat_inc(exp_err);
        idle(SL);
    endtask

    task automatic settle(input string tag);
        idle(3);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_pld_left"}, exp_q.size(), 32'd0);
        check({tag, "_ts_left"}, ts_q.size(), 32'd0);
        check({tag, "_evt_left"}, evt_q.size(), 32'd0);
    endtask

    // Run-time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin
        do_reset("reset");

        repeat (21) send_word(16'h0000);
        send_packet(16'hAAAA, 16'h0000, 16'hBEEF, 1'b1, -1, 0);
        settle("clean");
        check("clean_ts_held", ts_data, 16'hAAAA);

        do_reset("rst_b2b");
        for (int i = 0; i < 10; i++)
            send_packet(16'h1000 + DW'(i), {i[7:0], 8'h00}, 16'hBEEF, 1'b1, -1, 0);
        settle("b2b");

        do_reset("rst_bad");
        repeat ($urandom_range(1, 8)) send_word(16'h0000);
        send_packet(DW'($urandom_range(0, 16'hFFFF)), 16'h0100, 16'hBEEE, 1'b1, -1, 0);
        idle($urandom_range(0, 5));
        send_packet(DW'($urandom_range(0, 16'hFFFF)), 16'h0200, 16'hBEEF, 1'b1, -1, 0);
        settle("bad_ender");

        do_reset("rst_resync");
        send_packet(16'hAAAA, 16'h0300, 16'hDEAD, 1'b1, -1, 0);
        send_packet(16'hAAAA, 16'h0400, 16'hBEEF, 1'b0, -1, 0);
        settle("resync");

        do_reset("rst_stall");
        send_stalled(16'h1234, 16'h0500, 50);
        settle("stall_timeout");
        send_packet(16'hDEAD, 16'h0600, 16'hBEEF, 1'b1, 50, SL - 1);
        send_packet(DW'($urandom_range(0, 16'hFFFF)), 16'h0700, 16'hBEEF, 1'b1,
                    $urandom_range(0, PW - 1), $urandom_range(1, SL - 1));
        settle("stall_ok");

        do_reset("rst_mid");
        send_word(16'h0000);
        send_word(16'hDEAD);
        ts_q.push_back(16'h4444);
        send_word(16'h4444);
        for (int j = 0; j < 60; j++) begin
            exp_q.push_back({16'h0800 + DW'(j), (j == 0), 1'b0});
            send_word(16'h0800 + DW'(j));
        end
        do_reset("mid_payload");
        send_packet(16'h5555, 16'h0900, 16'hBEEF, 1'b1, -1, 0);
        settle("after_mid_rst");

        do_reset("rst_sat");
        for (int i = 0; i < CMAX + 2; i++)
            send_packet(DW'(i), 16'h0A00, 16'hBEEF, 1'b1, -1, 0);
        for (int i = 0; i < CMAX + 1; i++)
            send_packet(DW'(i), 16'h0B00, 16'h1234, 1'b1, -1, 0);
        settle("saturate");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
